// File: rtl/clint_trap_ctrl_pkg.sv
// Shared constants for the core-local trap controller: CSR addresses, cause codes,
// mstatus bit positions and the one-hot trap FSM encoding.
package clint_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    // Exception codes; interrupt causes additionally set the MSB of mcause.
    localparam int unsigned CODE_ECALL  = 11;
    localparam int unsigned CODE_EBREAK = 3;
    localparam int unsigned CODE_EXT    = 11;
    localparam int unsigned CODE_TIMER  = 7;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam int unsigned IRQ_TIMER = 0;
    localparam int unsigned IRQ_EXT   = 1;

    typedef enum logic [6:0] {
        IDLE      = 7'b000_0001,
        W_MEPC    = 7'b000_0010,
        W_MCAUSE  = 7'b000_0100,
        W_MSTATUS = 7'b000_1000,
        ASSERT    = 7'b001_0000,
        M_MSTATUS = 7'b010_0000,
        M_ASSERT  = 7'b100_0000
    } state_t;

endpackage

// File: rtl/clint_trap_ctrl_cause_enc.sv
// Combinational request arbiter: picks the winning trap source and builds its mcause.
module trap_cause_enc
    import clint_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INT_NUM    = 2
) (
    input  logic                  ecall,
    input  logic                  ebreak,
    input  logic                  mret,
    input  logic [INT_NUM-1:0]    int_flag,
    input  logic                  global_int_en,
    output logic                  accept,
    output logic                  is_mret,
    output logic                  is_int,
    output logic [DATA_WIDTH-1:0] cause
);

    always_comb begin
        accept  = 1'b0;
        is_mret = 1'b0;
        is_int  = 1'b0;
        cause   = '0;
        if (ecall) begin
            accept = 1'b1;
            cause  = DATA_WIDTH'(CODE_ECALL);
        end else if (ebreak) begin
            accept = 1'b1;
            cause  = DATA_WIDTH'(CODE_EBREAK);
        end else if (mret) begin
            accept  = 1'b1;
            is_mret = 1'b1;
        end else if (global_int_en && int_flag[IRQ_EXT]) begin
            accept = 1'b1;
            is_int = 1'b1;
            cause  = {1'b1, (DATA_WIDTH-1)'(CODE_EXT)};
        end else if (global_int_en && int_flag[IRQ_TIMER]) begin
            accept = 1'b1;
            is_int = 1'b1;
            cause  = {1'b1, (DATA_WIDTH-1)'(CODE_TIMER)};
        end
    end

endmodule

// File: rtl/clint_trap_ctrl.sv
// Core-local trap controller: sequences mepc/mcause/mstatus writes for traps,
// the mstatus restore for mret, stalls the pipeline and redirects fetch.
module clint_trap_ctrl
    import clint_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int INT_NUM        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ecall_i,
    input  logic                      ebreak_i,
    input  logic                      mret_i,
    input  logic [DATA_WIDTH-1:0]     inst_addr_i,
    input  logic                      jump_flag_i,
    input  logic [DATA_WIDTH-1:0]     jump_addr_i,
    input  logic [INT_NUM-1:0]        int_flag_i,
    input  logic                      global_int_en_i,
    input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
    input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      hold_flag_o,
    output logic                      int_assert_o,
    output logic [DATA_WIDTH-1:0]     int_addr_o
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cause_q, epc_q;
    logic                  cooldown;
    logic                  accept, is_mret, is_int;
    logic [DATA_WIDTH-1:0] enc_cause;
    logic                  take;
    logic [DATA_WIDTH-1:0] trap_mstatus, mret_mstatus;

    trap_cause_enc #(
        .DATA_WIDTH(DATA_WIDTH),
        .INT_NUM   (INT_NUM)
    ) u_enc (
        .ecall        (ecall_i),
        .ebreak       (ebreak_i),
        .mret         (mret_i),
        .int_flag     (int_flag_i),
        .global_int_en(global_int_en_i),
        .accept       (accept),
        .is_mret      (is_mret),
        .is_int       (is_int),
        .cause        (enc_cause)
    );

    // The IDLE cycle right after a redirect never accepts, giving fetch one clean cycle.
    assign take = (state == IDLE) && !cooldown && accept;

    always_comb begin
        trap_mstatus           = csr_mstatus_i;
        trap_mstatus[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
        trap_mstatus[MIE_BIT]  = 1'b0;
        mret_mstatus           = csr_mstatus_i;
        mret_mstatus[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
        mret_mstatus[MPIE_BIT] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            cooldown <= 1'b0;
        end else begin
            state    <= state_nxt;
            cooldown <= (state == ASSERT) || (state == M_ASSERT);
            if (take && !is_mret) begin
                cause_q <= enc_cause;
                epc_q   <= (is_int && jump_flag_i) ? jump_addr_i : inst_addr_i;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        hold_flag_o  = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (state)
            IDLE: begin
                if (take) begin
                    hold_flag_o = 1'b1;
                    state_nxt   = is_mret ? M_MSTATUS : W_MEPC;
                end
            end
            W_MEPC: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
                csr_wdata_o = epc_q;
                state_nxt   = W_MCAUSE;
            end
            W_MCAUSE: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
                csr_wdata_o = cause_q;
                state_nxt   = W_MSTATUS;
            end
            W_MSTATUS: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_wdata_o = trap_mstatus;
                state_nxt   = ASSERT;
            end
            ASSERT: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
                state_nxt    = IDLE;
            end
            M_MSTATUS: begin
                hold_flag_o = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_wdata_o = mret_mstatus;
                state_nxt   = M_ASSERT;
            end
            M_ASSERT: begin
                hold_flag_o  = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A reset cycle must not leak a half-finished CSR write.
        if (rst) begin
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            hold_flag_o  = 1'b0;
            int_assert_o = 1'b0;
            int_addr_o   = '0;
        end
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Table-driven check of clint_trap_ctrl: one row per clock cycle, inputs plus expected outputs.
module tb_clint_trap_ctrl;

    localparam logic [11:0] A_MS  = 12'h300;
    localparam logic [11:0] A_EPC = 12'h341;
    localparam logic [11:0] A_CA  = 12'h342;
    localparam logic [31:0] MT    = 32'h200;
    localparam logic [31:0] MEPC  = 32'h104;

    typedef struct {
        logic        rst, ecall, ebreak, mret, jf;
        logic [1:0]  intf;
        logic        gie;
        logic [31:0] pc, ja, mst;
        logic        chk;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        hold, ia;
        logic [31:0] iaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, ecall, ebreak, mret, jf, gie;
    logic [1:0]  intf;
    logic [31:0] pc, ja, mst, mtvec, mepc;
    logic        we, hold, ia;
    logic [11:0] wa;
    logic [31:0] wd, iaddr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clint_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ecall_i        (ecall),
        .ebreak_i       (ebreak),
        .mret_i         (mret),
        .inst_addr_i    (pc),
        .jump_flag_i    (jf),
        .jump_addr_i    (ja),
        .int_flag_i     (intf),
        .global_int_en_i(gie),
        .csr_mtvec_i    (mtvec),
        .csr_mepc_i     (mepc),
        .csr_mstatus_i  (mst),
        .csr_we_o       (we),
        .csr_waddr_o    (wa),
        .csr_wdata_o    (wd),
        .hold_flag_o    (hold),
        .int_assert_o   (ia),
        .int_addr_o     (iaddr)
    );

    function automatic vec_t mk(logic r, logic ec, logic eb, logic mr, logic j, logic [1:0] it,
                                logic g, logic [31:0] p, logic [31:0] jad, logic [31:0] ms,
                                logic ewe, logic [11:0] ewa, logic [31:0] ewd, logic eh,
                                logic eia, logic [31:0] eiaddr);
        vec_t v;
        v.rst = r; v.ecall = ec; v.ebreak = eb; v.mret = mr; v.jf = j; v.intf = it; v.gie = g;
        v.pc = p; v.ja = jad; v.mst = ms; v.chk = 1'b1;
        v.we = ewe; v.wa = ewa; v.wd = ewd; v.hold = eh; v.ia = eia; v.iaddr = eiaddr;
        return v;
    endfunction

    task automatic cmp(string nm, string tag, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s[%0d]: got %h want %h", nm, tag, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the edge, check outputs at the falling edge.
    task automatic run(vec_t v, string tag, int idx);
        rst = v.rst; ecall = v.ecall; ebreak = v.ebreak; mret = v.mret; jf = v.jf;
        intf = v.intf; gie = v.gie; pc = v.pc; ja = v.ja; mst = v.mst;
        @(negedge clk);
        if (v.chk) begin
            cmp("csr_we",   tag, idx, 32'(we),    32'(v.we));
            cmp("csr_waddr",tag, idx, 32'(wa),    32'(v.wa));
            cmp("csr_wdata",tag, idx, wd,         v.wd);
            cmp("hold",     tag, idx, 32'(hold),  32'(v.hold));
            cmp("int_assert",tag,idx, 32'(ia),    32'(v.ia));
            cmp("int_addr", tag, idx, iaddr,      v.iaddr);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        rst = 1'b1; ecall = 0; ebreak = 0; mret = 0; jf = 0; gie = 0; intf = 0;
        pc = 0; ja = 0; mst = 32'h8; mtvec = MT; mepc = MEPC;

        // reset state and idle
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        // ecall
        tbl.push_back(mk(0,1,0,0,0,0,0,'h100,0,8,     0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,'h100,0,8,     1,A_EPC,'h100,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         1,A_CA,11,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         1,A_MS,'h80,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,1,1,MT));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        // timer interrupt during taken jump
        tbl.push_back(mk(0,0,0,0,1,2'b01,1,'h500,'h40,8, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,'h500,0,8,     1,A_EPC,'h40,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         1,A_CA,32'h8000_0007,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         1,A_MS,'h80,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,1,1,MT));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,0,0,0));
        // both interrupts masked, then enabled: external wins
        tbl.push_back(mk(0,0,0,0,0,2'b11,0,'h600,0,8, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,2'b11,0,'h600,0,8, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,2'b11,1,'h600,0,8, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,2'b11,1,'h600,0,8, 1,A_EPC,'h600,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,2'b11,1,0,0,8,     1,A_CA,32'h8000_000B,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,2'b11,1,0,0,8,     1,A_MS,'h80,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,1,1,MT));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,0,0,0));
        // ebreak beats mret; other mstatus bits preserved
        tbl.push_back(mk(0,0,1,1,0,0,0,'h700,0,'hFFFF_FFFF, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'hFFFF_FFFF, 1,A_EPC,'h700,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'hFFFF_FFFF, 1,A_CA,3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'hFFFF_FFFF, 1,A_MS,'hFFFF_FFF7,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,1,1,MT));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        // mret with MPIE=1, then with MPIE=0/MIE=1
        tbl.push_back(mk(0,0,0,1,0,0,0,0,0,'h80,      0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h80,      1,A_MS,'h88,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h80,      0,0,0,1,1,MEPC));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h80,      0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,0,8,         0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         1,A_MS,'h80,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,1,1,MEPC));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) run(tbl[i], "tbl", i);

        // ecall and external interrupt together; interrupt kept high is taken at N+6
        seq.delete();
        seq.push_back(mk(0,1,0,0,0,2'b10,1,'h800,0,8, 0,0,0,1,0,0));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h800,0,8, 1,A_EPC,'h800,1,0,0));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h800,0,8, 1,A_CA,11,1,0,0));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h800,0,8, 1,A_MS,'h80,1,0,0));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h800,0,8, 0,0,0,1,1,MT));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h800,0,8, 0,0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,2'b10,1,'h900,0,8, 0,0,0,1,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,'h900,0,8,     1,A_EPC,'h900,1,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,0,0,8,         1,A_CA,32'h8000_000B,1,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,0,0,8,         1,A_MS,'h80,1,0,0));
        seq.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,1,1,MT));
        seq.push_back(mk(0,0,0,0,0,0,1,0,0,8,         0,0,0,0,0,0));
        foreach (seq[i]) run(seq[i], "reaccept", i);

        // reset at N+2 aborts the trap after mepc has been written
        seq.delete();
        seq.push_back(mk(0,1,0,0,0,0,0,'hA00,0,8,     0,0,0,1,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,'hA00,0,8,     1,A_EPC,'hA00,1,0,0));
        seq.push_back(mk(1,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        seq[2].chk = 1'b0;
        seq.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,0,8,         0,0,0,0,0,0));
        foreach (seq[i]) run(seq[i], "midrst", i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
